touch_scan_ctrl: RTL and testbench

TOUCH_SCAN_CTRL -- requirements
Module: touch_scan_ctrl

---
 rtl/touch_scan_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_touch_scan_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_scan_ctrl.sv
// APB3-controlled scan sequencer for a resistive touch ADC: X, Y, Z1 SPI frames
// (mode 0, 24 clocks each), stored atomically into readable result registers.
module touch_scan_ctrl #(
  parameter int CLKDIV_RST = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        SCLK,
  output logic        MOSI,
  output logic        CS_N,
  input  logic        MISO,
  input  logic        PENIRQ_N,
  output logic        IRQ
);

  typedef enum logic [2:0] {IDLE, WAIT_PEN, XFER, STORE, GAP} state_t;

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [5:0]  HS_LAST  = 6'd49;

  state_t      state, nxt;
  logic        frame_start;

  logic        acc, wr;
  logic [2:0]  reg_sel;
  logic        wr_ctrl, wr_start, wr_status, wr_clkdiv;

  logic [2:0]  ctrl;
  logic [7:0]  clkdiv;
  logic        done;
  logic [11:0] x_reg, y_reg, z_reg;
  logic        pen_s1, pen_s2, pen;

  logic [7:0]  div_lat, div_cnt;
  logic [5:0]  hstep, hstep_n;
  logic [1:0]  ch, ch_nxt;
  logic [11:0] res_sh, x_tmp, y_tmp, z_tmp;
  logic [15:0] gap_cnt;
  logic        abort_q;
  logic        sclk_q, mosi_q, cs_n_q;
  logic        tick, frame_end, do_abort;
  logic [7:0]  cmd_cur, cmd_nxt;
  logic        unused_bits;

  function automatic logic [7:0] cmd_byte(input logic [1:0] c);
    case (c)
      2'd0:    return 8'hD0;
      2'd1:    return 8'h90;
      default: return 8'hB0;
    endcase
  endfunction

  assign acc       = PSEL & PENABLE;
  assign wr        = acc & PWRITE;
  assign reg_sel   = PADDR[4:2];
  assign wr_ctrl   = wr && (reg_sel == 3'd0);
  assign wr_start  = wr && (reg_sel == 3'd1);
  assign wr_status = wr && (reg_sel == 3'd2);
  assign wr_clkdiv = wr && (reg_sel == 3'd5);

  assign pen       = ~pen_s2;
  assign tick      = (div_cnt == div_lat);
  assign frame_end = (state == XFER) && tick && (hstep == HS_LAST);
  assign do_abort  = abort_q | ~ctrl[0];
  assign hstep_n   = hstep + 6'd1;
  assign ch_nxt    = (state == XFER) ? ch + 2'd1 : 2'd0;
  assign cmd_cur   = cmd_byte(ch);
  assign cmd_nxt   = cmd_byte(ch_nxt);

  assign PREADY      = 1'b1;
  assign PSLVERR     = 1'b0;
  assign SCLK        = sclk_q;
  assign MOSI        = mosi_q;
  assign CS_N        = cs_n_q;
  assign IRQ         = done & ctrl[2];
  assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:8]};

  always_comb begin
    PRDATA = 32'd0;
    if (acc && !PWRITE) begin
      case (reg_sel)
        3'd0:    PRDATA = {29'd0, ctrl};
        3'd2:    PRDATA = {29'd0, pen, done, state != IDLE};
        3'd3:    PRDATA = {4'd0, y_reg, 4'd0, x_reg};
        3'd4:    PRDATA = {20'd0, z_reg};
        3'd5:    PRDATA = {24'd0, clkdiv};
        default: PRDATA = 32'd0;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt         = state;
    frame_start = 1'b0;
    case (state)
      IDLE:     if (ctrl[0] && (wr_start || ctrl[1])) nxt = WAIT_PEN;
      WAIT_PEN: begin
        if (!ctrl[0]) nxt = IDLE;
        else if (pen) begin
          nxt         = XFER;
          frame_start = 1'b1;
        end
      end
      XFER: begin
        if (frame_end) begin
          if (do_abort)         nxt = IDLE;
          else if (ch == 2'd2)  nxt = STORE;
          else                  frame_start = 1'b1;
        end
      end
      STORE:    nxt = ctrl[1] ? GAP : IDLE;
      GAP: begin
        if (!ctrl[0])                nxt = IDLE;
        else if (gap_cnt == GAP_LAST) nxt = WAIT_PEN;
      end
      default:  nxt = IDLE;
    endcase
  end

  // Register file, pen synchronizer and atomic result update.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      ctrl   <= 3'd0;
      clkdiv <= 8'(CLKDIV_RST);
      done   <= 1'b0;
      x_reg  <= 12'd0;
      y_reg  <= 12'd0;
      z_reg  <= 12'd0;
      pen_s1 <= 1'b1;
      pen_s2 <= 1'b1;
    end else begin
      pen_s1 <= PENIRQ_N;
      pen_s2 <= pen_s1;
      if (wr_ctrl)   ctrl   <= PWDATA[2:0];
      if (wr_clkdiv) clkdiv <= PWDATA[7:0];
      if (state == STORE) begin
        done  <= 1'b1;
        x_reg <= x_tmp;
        y_reg <= y_tmp;
        z_reg <= z_tmp;
      end else if (wr_status && PWDATA[1]) begin
        done <= 1'b0;
      end
    end
  end

  // SPI frame engine: hstep 0 is the CS_N lead, odd steps SCLK high, 49 is the CS_N-high tail.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      div_lat <= 8'd0;
      div_cnt <= 8'd0;
      hstep   <= 6'd0;
      ch      <= 2'd0;
      res_sh  <= 12'd0;
      x_tmp   <= 12'd0;
      y_tmp   <= 12'd0;
      z_tmp   <= 12'd0;
      gap_cnt <= 16'd0;
      abort_q <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;
      if (state == XFER) abort_q <= abort_q | (wr_ctrl & ~PWDATA[0]);
      else               abort_q <= 1'b0;

      if (frame_end) begin
        case (ch)
          2'd0:    x_tmp <= res_sh;
          2'd1:    y_tmp <= res_sh;
          default: z_tmp <= res_sh;
        endcase
      end

      if (frame_start) begin
        div_lat <= clkdiv;
        div_cnt <= 8'd0;
        hstep   <= 6'd0;
        ch      <= ch_nxt;
        res_sh  <= 12'd0;
        cs_n_q  <= 1'b0;
        sclk_q  <= 1'b0;
        mosi_q  <= cmd_nxt[7];
      end else if (state == XFER) begin
        if (!tick) begin
          div_cnt <= div_cnt + 8'd1;
        end else if (hstep != HS_LAST) begin
          div_cnt <= 8'd0;
          hstep   <= hstep_n;
          if (hstep_n == HS_LAST) begin
            cs_n_q <= 1'b1;
            mosi_q <= 1'b0;
          end else if (hstep_n[0]) begin
            sclk_q <= 1'b1;
            // Rising edges 10..21 carry the 12-bit conversion result.
            if (hstep_n >= 6'd19 && hstep_n <= 6'd41) res_sh <= {res_sh[10:0], MISO};
          end else begin
            sclk_q <= 1'b0;
            mosi_q <= (hstep_n < 6'd16) ? cmd_cur[3'd7 - hstep_n[3:1]] : 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_touch_scan_ctrl.sv
// Directed bench for touch_scan_ctrl: APB driver, mode-0 ADC model and a frame
// scoreboard checking command bytes, pulse counts and SCLK periods per frame.
module tb_touch_scan_ctrl;

  logic        PCLK, PRESERN, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR, SCLK, MOSI, CS_N, MISO, PENIRQ_N, IRQ;

  touch_scan_ctrl #(.CLKDIV_RST(4), .GAP_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .SCLK(SCLK), .MOSI(MOSI), .CS_N(CS_N), .MISO(MISO), .PENIRQ_N(PENIRQ_N), .IRQ(IRQ)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [7:0] cmd;
    int         per;
  } frame_t;

  frame_t      exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          npulse = 0, nfall = 0, frames_started = 0;
  int          t1 = 0, t23 = 0, p_first = 0, p_last = 0;
  logic [7:0]  cmd_cap = 8'd0;
  logic [11:0] adc_x = 12'd0, adc_y = 12'd0, adc_z = 12'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [11:0] adc_val(input logic [7:0] c);
    case (c)
      8'hD0:   return adc_x;
      8'h90:   return adc_y;
      8'hB0:   return adc_z;
      default: return 12'd0;
    endcase
  endfunction

  always @(posedge PCLK) cyc++;

  // Frame monitor and ADC model.
  always @(negedge CS_N) if (PRESERN === 1'b1) begin
    npulse = 0;
    nfall  = 0;
    cmd_cap = 8'd0;
    MISO = 1'b0;
    frames_started++;
  end

  always @(posedge SCLK) if (CS_N === 1'b0) begin
    npulse++;
    if (npulse <= 8) cmd_cap = {cmd_cap[6:0], MOSI};
    if (npulse == 1) t1 = cyc;
    if (npulse == 2) p_first = cyc - t1;
    if (npulse == 23) t23 = cyc;
    if (npulse == 24) p_last = cyc - t23;
  end

  always @(negedge SCLK) if (CS_N === 1'b0 && PRESERN === 1'b1) begin
    logic [11:0] v;
    nfall++;
    v = adc_val(cmd_cap);
    if (nfall >= 9 && nfall <= 20) MISO = v[20 - nfall];
    else                           MISO = 1'b0;
  end

  always @(posedge CS_N) if (PRESERN === 1'b1) begin
    frame_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_frame", 32'(frames_started), 32'(-1));
    end else begin
      e = exp_q.pop_front();
      chk("frame_cmd", 32'(cmd_cap), 32'(e.cmd));
      chk("frame_pulses", 32'(npulse), 32'd24);
      chk("sclk_per_first", 32'(p_first), 32'(e.per));
      chk("sclk_per_last", 32'(p_last), 32'(e.per));
    end
  end

  task automatic push_frame(input logic [7:0] c, input int div);
    frame_t f;
    f.cmd = c;
    f.per = 2 * (div + 1);
    exp_q.push_back(f);
  endtask

  task automatic push_scan(input int div);
    push_frame(8'hD0, div);
    push_frame(8'h90, div);
    push_frame(8'hB0, div);
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #3 d = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp_v);
    logic [31:0] d;
    apb_read(a, d);
    chk(tag, d, exp_v);
  endtask

  task automatic wait_idle(input string tag, input int max_reads);
    logic [31:0] d;
    logic        ok;
    ok = 1'b0;
    for (int i = 0; i < max_reads; i++) begin
      apb_read(32'h08, d);
      if (d[0] == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_sig(input string tag, input int which, input logic val, input int max_cyc);
    logic ok;
    logic s;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge PCLK); #1;
      s = (which == 0) ? CS_N : (which == 1) ? SCLK : IRQ;
      if (s === val) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    int          base, lat;
    PRESERN = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 32'd0; PWDATA = 32'd0; MISO = 1'b0; PENIRQ_N = 1'b1;

    // Reset state
    #3 PRESERN = 1'b0;
    #20;
    chk("rst_cs_n", 32'(CS_N), 32'd1);
    chk("rst_sclk", 32'(SCLK), 32'd0);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_irq", 32'(IRQ), 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("pready", 32'(PREADY), 32'd1);
    chk("pslverr", 32'(PSLVERR), 32'd0);
    @(posedge PCLK); #1 PRESERN = 1'b1;
    rd_chk("rst_ctrl", 32'h00, 32'd0);
    rd_chk("rst_clkdiv", 32'h14, 32'd4);
    rd_chk("rst_xy", 32'h0C, 32'd0);
    rd_chk("rst_z", 32'h10, 32'd0);
    rd_chk("rst_status", 32'h08, 32'd0);
    rd_chk("unmapped", 32'h18, 32'd0);

    // Single scan, default divider
    adc_x = 12'hABC; adc_y = 12'h123; adc_z = 12'h456;
    push_scan(4);
    apb_write(32'h00, 32'h1);
    apb_write(32'h04, 32'h1);
    PENIRQ_N = 1'b0;
    wait_idle("scan1_tmo", 2000);
    rd_chk("scan1_xy", 32'h0C, 32'h0123_0ABC);
    rd_chk("scan1_z", 32'h10, 32'h0000_0456);
    rd_chk("scan1_status", 32'h08, 32'h6);
    chk("scan1_q_empty", 32'(exp_q.size()), 32'd0);
    apb_write(32'h08, 32'h2);
    rd_chk("w1c_status", 32'h08, 32'h4);

    // CLKDIV=3 for first frame, then 0 written mid-frame applies from the next frame
    adc_x = 12'hFFF; adc_y = 12'h000; adc_z = 12'h800;
    apb_write(32'h14, 32'd3);
    push_frame(8'hD0, 3);
    push_frame(8'h90, 0);
    push_frame(8'hB0, 0);
    apb_write(32'h04, 32'h1);
    wait_sig("div_cs_low_tmo", 0, 1'b0, 200);
    apb_write(32'h14, 32'd0);
    wait_idle("scan2_tmo", 2000);
    rd_chk("scan2_xy", 32'h0C, 32'h0000_0FFF);
    rd_chk("scan2_z", 32'h10, 32'h0000_0800);
    chk("scan2_q_empty", 32'(exp_q.size()), 32'd0);
    apb_write(32'h08, 32'h2);

    // START with pen up waits; pen-down reaches CS_N after the synchronizer
    PENIRQ_N = 1'b1;
    repeat (4) @(posedge PCLK);
    adc_x = 12'h135; adc_y = 12'h246; adc_z = 12'h357;
    apb_write(32'h04, 32'h1);
    repeat (20) @(posedge PCLK);
    rd_chk("penwait_status", 32'h08, 32'h1);
    chk("penwait_cs_n", 32'(CS_N), 32'd1);
    push_scan(0);
    @(posedge PCLK); #1 PENIRQ_N = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge PCLK); #1;
      if (CS_N === 1'b0) begin
        lat = i;
        break;
      end
    end
    chk("pen_sync_latency", 32'(lat), 32'd3);
    wait_idle("scan3_tmo", 2000);
    rd_chk("scan3_xy", 32'h0C, 32'h0246_0135);
    rd_chk("scan3_z", 32'h10, 32'h0000_0357);
    apb_write(32'h08, 32'h2);

    // Continuous mode with interrupt, W1C drops IRQ until the next STORE
    adc_x = 12'h5A5; adc_y = 12'hA5A; adc_z = 12'hFFF;
    push_scan(0);
    push_scan(0);
    apb_write(32'h00, 32'h7);
    wait_sig("cont_irq1_tmo", 2, 1'b1, 2000);
    rd_chk("cont_xy", 32'h0C, 32'h0A5A_05A5);
    rd_chk("cont_z", 32'h10, 32'h0000_0FFF);
    apb_write(32'h08, 32'h2);
    chk("cont_irq_cleared", 32'(IRQ), 32'd0);
    wait_sig("cont_irq2_tmo", 2, 1'b1, 2000);
    apb_write(32'h00, 32'h0);
    wait_idle("cont_stop_tmo", 200);
    chk("cont_q_empty", 32'(exp_q.size()), 32'd0);

    // Clearing EN during the Y frame discards the scan
    apb_write(32'h08, 32'h2);
    apb_write(32'h00, 32'h1);
    adc_x = 12'h777; adc_y = 12'h888; adc_z = 12'h999;
    push_frame(8'hD0, 0);
    push_frame(8'h90, 0);
    base = frames_started;
    apb_write(32'h04, 32'h1);
    for (int i = 0; i < 2000; i++) begin
      @(posedge PCLK); #1;
      if (frames_started >= base + 2) break;
    end
    chk("abort_y_started", 32'(frames_started - base), 32'd2);
    apb_write(32'h00, 32'h0);
    wait_idle("abort_tmo", 500);
    repeat (30) @(posedge PCLK);
    rd_chk("abort_xy", 32'h0C, 32'h0A5A_05A5);
    rd_chk("abort_z", 32'h10, 32'h0000_0FFF);
    rd_chk("abort_status", 32'h08, 32'h4);
    chk("abort_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame
    apb_write(32'h14, 32'd1);
    apb_write(32'h00, 32'h5);
    apb_write(32'h04, 32'h1);
    wait_sig("midrst_sclk_tmo", 1, 1'b1, 400);
    #1 PRESERN = 1'b0;
    #1;
    chk("midrst_cs_n", 32'(CS_N), 32'd1);
    chk("midrst_sclk", 32'(SCLK), 32'd0);
    chk("midrst_mosi", 32'(MOSI), 32'd0);
    chk("midrst_irq", 32'(IRQ), 32'd0);
    PENIRQ_N = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 PRESERN = 1'b1;
    repeat (3) @(posedge PCLK);
    rd_chk("midrst_ctrl", 32'h00, 32'd0);
    rd_chk("midrst_clkdiv", 32'h14, 32'd4);
    rd_chk("midrst_xy", 32'h0C, 32'd0);
    rd_chk("midrst_z", 32'h10, 32'd0);
    rd_chk("midrst_status", 32'h08, 32'd0);
    chk("midrst_cs_idle", 32'(CS_N), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
